// File: rtl/rs_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rs_tx -- RS-485 serial transmitter.
//
// Takes one byte per valid/ready handshake and shifts it out on tx as a
// 12-bit frame: start(0), 8 data bits LSB first, even parity, two stops(1).
// Each bit lasts DIV clk50 cycles (integer divide of CLK_FREQ by BAUD).
//
// Optional feature (macro RS_TX_HOLD_EN): a one-byte holding register lets
// the next byte be accepted while a frame is on the line, and frames are
// chained back-to-back without an idle cycle.
//
// Ports:
//   clk50     in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   tx_data   in   byte to send, sampled on handshake
//   tx_valid  in   tx_data valid
//   tx_ready  out  a byte can be accepted this cycle
//   tx        out  serial line, idle high, driven from a flop
//   tx_busy   out  frame in progress (START through last STOP)
//   tx_done   out  one-cycle pulse after the final stop bit completes
// ---------------------------------------------------------------------------
module rs_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_FREQ / BAUD
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int            DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  logic accept;
  logic bit_end;
  logic last_stop;

  assign accept    = tx_valid && tx_ready;
  assign bit_end   = (div_cnt == DIV_MAX);
  // Final cycle of the second stop bit; the frame ends on this edge.
  assign last_stop = (state == STOP) && bit_end && stop_cnt;

`ifdef RS_TX_HOLD_EN
  logic [7:0] hold;
  logic       hold_full;
  logic       chain;
  logic [7:0] next_byte;

  assign tx_ready  = !hold_full;
  // Start the next frame immediately if a byte is waiting in hold, or one
  // is being handed over on this very edge while hold is empty.
  assign chain     = last_stop && (hold_full || accept);
  assign next_byte = hold_full ? hold : tx_data;
`else
  logic ready_q;

  assign tx_ready = ready_q;
`endif

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

  // Frame sequencer: state, bit divider, shift register and all outputs.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      parity   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RS_TX_HOLD_EN
      hold      <= '0;
      hold_full <= 1'b0;
`else
      ready_q  <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (accept) begin
            shift   <= tx_data;
            parity  <= ^tx_data;
            state   <= START;
            tx_q    <= 1'b0;
            div_cnt <= '0;
            busy_q  <= 1'b1;
`ifndef RS_TX_HOLD_EN
            ready_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_q    <= shift[0];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              tx_q  <= parity;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shift[1] becomes the new shift[0] after this edge.
              tx_q    <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            div_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= STOP;
            tx_q     <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (stop_cnt) begin
              done_q   <= 1'b1;
              stop_cnt <= 1'b0;
`ifdef RS_TX_HOLD_EN
              if (chain) begin
                shift  <= next_byte;
                parity <= ^next_byte;
                state  <= START;
                tx_q   <= 1'b0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
`else
              state   <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
`endif
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase

`ifdef RS_TX_HOLD_EN
      // Hold fills on any accept outside IDLE, except when the byte is
      // consumed directly by a chained start with hold empty. An accept on
      // the unload edge refills hold, so hold_full stays set.
      if (accept && (state != IDLE) && !(last_stop && !hold_full)) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (last_stop && hold_full) begin
        hold_full <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rs_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rs_tx -- bench for rs_tx with a short bit period (DIV=4).
// Stimulus pushes the expected byte/parity of each accepted frame into a
// scoreboard queue; an independent monitor detects start bits on tx, pops
// the expectation and checks every bit level, tx_busy and the tx_done pulse.
// ---------------------------------------------------------------------------
module tb_rs_tx;

  localparam int CLK_FREQ = 40;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 12 * DIV;

`ifdef RS_TX_HOLD_EN
  localparam int SPACING  = FRAME;
  localparam int EXP_DONE = 11;
`else
  localparam int SPACING  = FRAME + 1;
  localparam int EXP_DONE = 8;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk50;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  exp_t sb[$];
  int   starts[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_pulses = 0;

  rs_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk50   (clk50),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // Free-running clock and a cycle counter used to time frame starts.
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  // Count every tx_done pulse so spurious ones (e.g. after reset) show up.
  always @(negedge clk50) if (tx_done === 1'b1) done_pulses <= done_pulses + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Present a byte, wait (bounded) for tx_ready, record the expected frame
  // at the accepting edge. keep=1 leaves tx_valid high afterwards.
  task automatic applyStimulus(input logic [7:0] d, input logic p, input bit keep, output int acc_cyc);
    int n = 0;
    logic was_busy;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 40 * DIV) begin
      @(posedge clk50); #1;
      n++;
    end
    if (tx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: byte %0h never accepted", d);
      tx_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    was_busy = tx_busy;
    sb.push_back('{d, p});
    @(posedge clk50); #1;
    acc_cyc = cyc;
    if (!was_busy) begin
      checkOutput($sformatf("start_latency_tx_%0h", d), tx, 1'b0);
      checkOutput($sformatf("start_busy_%0h", d), tx_busy, 1'b1);
    end
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sb.size() != 0 || tx_busy !== 1'b0) && n < 40 * DIV) begin
      @(posedge clk50); #1;
      n++;
    end
    if (sb.size() != 0 || tx_busy !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: busy=%0b queued=%0d", tx_busy, sb.size());
    end
    repeat (4) begin @(posedge clk50); #1; end
  endtask

  // Monitor: a low tx outside reset opens a frame. Each bit is checked on
  // its first and last cycle; reset mid-frame abandons the frame.
  initial begin : monitor
    exp_t       e;
    logic [11:0] fr;
    bit          aborted;
    int          busy_bad;
    int          done_bad;
    forever begin
      @(negedge clk50);
      while (rst === 1'b0 && tx === 1'b0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_frame: start bit with empty scoreboard at cycle %0d", cyc);
          e = '{8'h00, 1'b0};
        end else begin
          e = sb.pop_front();
        end
        fr = {2'b11, e.p, e.d, 1'b0};
        starts.push_back(cyc);
        aborted  = 1'b0;
        busy_bad = 0;
        done_bad = 0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk50);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx_busy !== 1'b1) busy_bad++;
          if (tx_done !== 1'b0) done_bad++;
          if ((k % DIV) == 0 || (k % DIV) == DIV - 1)
            checkOutput($sformatf("frame%0h_bit%0d_c%0d", e.d, k / DIV, k % DIV), tx, fr[k / DIV]);
        end
        if (!aborted) begin
          checkOutput($sformatf("frame%0h_busy", e.d), busy_bad, 0);
          checkOutput($sformatf("frame%0h_done_early", e.d), done_bad, 0);
          @(negedge clk50);
          checkOutput($sformatf("frame%0h_done_pulse", e.d), tx_done, 1'b1);
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk50);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed vectors: byte and hand-computed even parity.
  initial begin : stimulus
    logic [7:0] vec_d [5] = '{8'hA5, 8'h07, 8'h00, 8'hFF, 8'h80};
    logic       vec_p [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int a1, a2, a3, n0;

    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    repeat (3) @(posedge clk50);
    #1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", tx_busy, 1'b0);
    checkOutput("reset_done", tx_done, 1'b0);
    checkOutput("reset_ready", tx_ready, 1'b1);
    rst      = 1'b0;
    tx_valid = 1'b0;
    repeat (3) begin @(posedge clk50); #1; end
    checkOutput("idle_after_reset_tx", tx, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vec_d[i], vec_p[i], 1'b0, a1);
      waitIdle();
    end

    // tx_valid held across two bytes: exactly two frames, fixed spacing.
    n0 = starts.size();
    applyStimulus(8'hA5, 1'b0, 1'b1, a1);
    applyStimulus(8'h5A, 1'b0, 1'b0, a2);
    waitIdle();
    checkOutput("b2b_frame_count", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2)
      checkOutput("b2b_start_spacing", starts[n0 + 1] - starts[n0], SPACING);

    // One-cycle reset during data bit 3 abandons the frame.
    applyStimulus(8'hC3, 1'b0, 1'b0, a1);
    repeat (4 * DIV + 1) begin @(posedge clk50); #1; end
    rst = 1'b1;
    @(posedge clk50); #1;
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_ready", tx_ready, 1'b1);
    checkOutput("midreset_busy", tx_busy, 1'b0);
    checkOutput("midreset_done", tx_done, 1'b0);
    rst = 1'b0;
    repeat (FRAME + 4) begin @(posedge clk50); #1; end
    applyStimulus(8'h3C, 1'b0, 1'b0, a1);
    waitIdle();

`ifdef RS_TX_HOLD_EN
    // Holding register: 0x22 parks during 0x11, 0x33 waits for the unload.
    n0 = starts.size();
    applyStimulus(8'h11, 1'b0, 1'b0, a1);
    repeat (DIV) begin @(posedge clk50); #1; end
    checkOutput("hold_ready_before", tx_ready, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b0, a2);
    checkOutput("hold_ready_after", tx_ready, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0, a3);
    checkOutput("hold_accept3_cycle", a3 - a1, FRAME + 1);
    waitIdle();
    checkOutput("hold_frame_count", starts.size() - n0, 3);
    if (starts.size() >= n0 + 3) begin
      checkOutput("hold_spacing_12", starts[n0 + 1] - starts[n0], FRAME);
      checkOutput("hold_spacing_23", starts[n0 + 2] - starts[n0 + 1], FRAME);
    end
`endif

    repeat (20 * DIV) begin @(posedge clk50); #1; end
    checkOutput("done_pulse_count", done_pulses, EXP_DONE);
    checkOutput("scoreboard_empty", sb.size(), 0);
    checkOutput("final_tx_idle", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
